// File: rtl/preamble101_tx.sv
// Serial "101"-preamble frame transmitter: preamble, WIDTH data bits MSB first, guard bit.
// Build option: define PREAMBLE101_TX_PARITY_EN to insert an even-parity bit before the guard.
module preamble101_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_A = 3'd1,
    PRE_B = 3'd2,
    PRE_C = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    GUARD = 3'd6
  } state_t;

  state_t            state, nxt;
  logic [WIDTH-1:0]  sr;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              last_bit;

  assign accept   = (state == IDLE) && tx_valid;
  assign last_bit = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Illegal encodings fall into the default arm and recover to IDLE.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:  nxt = tx_valid ? PRE_A : IDLE;
      PRE_A: nxt = PRE_B;
      PRE_B: nxt = PRE_C;
      PRE_C: nxt = DATA;
`ifdef PREAMBLE101_TX_PARITY_EN
      DATA:  nxt = last_bit ? PAR : DATA;
      PAR:   nxt = GUARD;
`else
      DATA:  nxt = last_bit ? GUARD : DATA;
`endif
      GUARD: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= data_in;
      cnt <= '0;
    end else if (state == DATA) begin
      sr  <= sr << 1;
      cnt <= cnt + 1'b1;
    end
  end

`ifdef PREAMBLE101_TX_PARITY_EN
  logic par;

  // Parity of the word as latched, not of the shifting register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       par <= 1'b0;
    else if (accept) par <= ^data_in;
  end
`endif

  always_comb begin
    out  = 1'b0;
    busy = (state != IDLE);
    done = (state == GUARD);
    case (state)
      PRE_A, PRE_C: out = 1'b1;
      DATA:         out = sr[WIDTH-1];
`ifdef PREAMBLE101_TX_PARITY_EN
      PAR:          out = par;
`endif
      default:      out = 1'b0;
    endcase
  end

  assign tx_ready = ~busy;

endmodule

// File: tb/tb_preamble101_tx.sv
// Self-checking bench for preamble101_tx (WIDTH=8), randomized frames against a bit-position model.
module tb_preamble101_tx;

  localparam int W = 8;
`ifdef PREAMBLE101_TX_PARITY_EN
  localparam int F = W + 5;
`else
  localparam int F = W + 4;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         tx_valid;
  logic [W-1:0] data_in;
  logic         tx_ready, out, busy, done;

  int checks = 0;
  int errors = 0;

  preamble101_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .data_in(data_in),
    .tx_ready(tx_ready), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line value in frame cycle i (1..F) for word d.
  function automatic logic exp_bit(input logic [W-1:0] d, input int i);
    if (i <= 3)     return (i != 2);
    if (i <= 3 + W) return d[W - 1 - (i - 4)];
`ifdef PREAMBLE101_TX_PARITY_EN
    if (i == 4 + W) return ^d;
`endif
    return 1'b0;
  endfunction

  task automatic send(input logic [W-1:0] d);
    tx_valid = 1'b1;
    data_in  = d;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: tx_ready=%b expected 1", tx_ready);
    end
    tick();
    tx_valid = 1'b0;
  endtask

  // Called in cycle 1 of a frame; returns in cycle F+1.
  task automatic check_stream(input logic [W-1:0] d, input bit noise, input bit keep_valid);
    for (int i = 1; i <= F; i++) begin
      if (noise && i >= 2 && i <= 10) begin
        tx_valid = 1'($urandom_range(0, 1));
        data_in  = 8'h3C;
      end else if (!keep_valid) begin
        tx_valid = 1'b0;
      end
      checks++;
      if (out !== exp_bit(d, i)) begin
        errors++;
        $display("FAIL frame_out d=%h cycle %0d: out=%b expected %b", d, i, out, exp_bit(d, i));
      end
      checks++;
      if (done !== (i == F) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL frame_ctrl d=%h cycle %0d: done=%b busy=%b tx_ready=%b expected done=%b busy=1 tx_ready=0",
                 d, i, done, busy, tx_ready, (i == F));
      end
      tick();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out !== 1'b0) begin
      errors++;
      $display("FAIL frame_end d=%h: tx_ready=%b busy=%b done=%b out=%b expected 1 0 0 0",
               d, tx_ready, busy, done, out);
    end
  endtask

  task automatic test_reset();
    send(8'hA5);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%b tx_ready=%b busy=%b done=%b expected 0 1 0 0",
               out, tx_ready, busy, done);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: out=%b tx_ready=%b busy=%b done=%b expected 0 1 0 0",
                 i, out, tx_ready, busy, done);
      end
      tick();
    end
  endtask

  task automatic test_single();
`ifdef PREAMBLE101_TX_PARITY_EN
    logic [F-1:0] golden = 13'b1011010010100;
`else
    logic [F-1:0] golden = 12'b101101001010;
`endif
    logic [F-1:0] seen = '0;
    send(8'hA5);
    for (int i = 1; i <= F; i++) begin
      seen[F - i] = out;
      checks++;
      if (done !== (i == F)) begin
        errors++;
        $display("FAIL single_done cycle %0d: done=%b expected %b", i, done, (i == F));
      end
      tick();
    end
    checks++;
    if (seen !== golden) begin
      errors++;
      $display("FAIL single_stream: got %b expected %b", seen, golden);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: tx_ready=%b expected 1", tx_ready);
    end
  endtask

  task automatic test_parity();
    send(8'hA5);
    check_stream(8'hA5, 1'b0, 1'b0);
    send(8'h07);
    check_stream(8'h07, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1;
    data_in  = 8'hFF;
    tick();
    data_in = 8'h00;
    check_stream(8'hFF, 1'b0, 1'b1);
    tick();
    tx_valid = 1'b0;
    check_stream(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_input();
    send(8'hA5);
    check_stream(8'hA5, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    send(8'hA5);
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: out=%b busy=%b tx_ready=%b done=%b expected 0 0 1 0",
               out, busy, tx_ready, done);
    end
    tick();
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < F + 2; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) cyc++;
      tick();
    end
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL midreset_nodone: %0d cycles with done/busy set, expected 0", cyc);
    end
    send(8'h81);
    check_stream(8'h81, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int n = 0; n < 25; n++) begin
      d = W'($urandom);
      send(d);
      check_stream(d, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    data_in  = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/preamble101_tx.md
# preamble101_tx

Serial frame transmitter that drives a single-bit line with a fixed "101" preamble followed by a parallel data word shifted out MSB first. It is the sending end for the team's "101" sequence-detector receivers. It sits between a parallel producer, connected through a valid/ready handshake, and the serial line feeding the detector. It is built as a Moore FSM, so the line output depends only on registered state.

## Interface

**Parameters**

- WIDTH, 8, data word width in bits (≥1)

**Ports**

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- tx_valid  input  1  producer has a word on data_in
- data_in  input  WIDTH  word to transmit; sampled only on the accept edge
- tx_ready  output  1  block is idle and can accept a word
- out  output  1  serial line
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse marking the last bit of a frame

## Operation

- States: IDLE, PRE_A (out=1), PRE_B (out=0), PRE_C (out=1), DATA, PAR (only with macro), GUARD (out=0).
- IDLE:
  - tx_ready=1, busy=0, out=0.
  - Accept occurs on a rising edge with tx_valid&&tx_ready. On accept, data_in is loaded into the shift register and the FSM goes to PRE_A.
- PRE_A → PRE_B → PRE_C → DATA: one cycle each, unconditional.
- DATA:
  - out = shift register MSB.
  - The shift register shifts left each cycle, and a bit counter counts 0..WIDTH-1.
  - After WIDTH cycles the FSM goes to PAR if enabled, otherwise to GUARD.
- GUARD:
  - out=0, done=1.
  - Next state is always IDLE. There is no direct GUARD→PRE_A transition.
- busy=1 in every state except IDLE. tx_ready is the exact complement of busy.
- tx_valid and data_in are ignored while busy. A word is never accepted in the middle of a frame.
- tx_ready, busy, out and done are decoded from registers only. There is no combinational input-to-output path.
- Unused or illegal state encodings return to IDLE on the next edge.
- Receiver-side false matches of "101" inside the data are the receiver's responsibility; this block applies no bit stuffing.

## Timing

- Reset values: out=0, tx_ready=1, busy=0, done=0. State=IDLE, shift register and counter cleared.
- Reset mid-frame: all outputs take their reset values immediately (asynchronous). The frame is dropped and no done pulse is issued.
- Cycle numbering: accept edge = edge 0.
  - Cycles 1–3: preamble 1,0,1.
  - Cycles 4..3+WIDTH: data bits, MSB first.
  - Parity bit, if enabled, follows the data.
  - Guard bit is the last bit, with done=1.
- Frame length F = WIDTH+4, or WIDTH+5 with parity.
- tx_ready returns high in cycle F+1. Minimum accept-to-accept spacing is F+1 edges.
- With tx_valid held high continuously, the next word is accepted on edge F+1.

## Configuration

- Macro: PREAMBLE101_TX_PARITY_EN.
- Defined:
  - PAR state is inserted between DATA and GUARD.
  - out = even parity, i.e. the XOR of all WIDTH data bits latched at accept.
  - F = WIDTH+5.
- Undefined:
  - No PAR state and no parity logic.
  - DATA goes directly to GUARD, and F = WIDTH+4.

## Test plan

- Reset:
  - Assert reset asynchronously between edges.
  - out=0, tx_ready=1, busy=0, done=0 immediately.
  - These values hold with tx_valid=0 for 20 cycles.
- Single frame, WIDTH=8, no parity:
  - Stimulus: data_in=8'hA5, tx_valid pulsed for one cycle.
  - out cycles 1–12 = 1,0,1,1,0,1,0,0,1,0,1,0.
  - done=1 only in cycle 12; tx_ready=1 in cycle 13.
- Parity enabled:
  - 8'hA5: parity bit in cycle 12 = 0, guard in cycle 13.
  - 8'h07: cycles 4–11 = 0,0,0,0,0,1,1,1, parity in cycle 12 = 1.
- Back-to-back:
  - Stimulus: tx_valid held high with 8'hFF then 8'h00.
  - Second accept on edge 13, not earlier.
  - Second frame out = 1,0,1,0×8,0.
- Ignored input:
  - Stimulus: toggle tx_valid and change data_in to 8'h3C during cycles 2–10 of an 8'hA5 frame.
  - The transmitted bit stream is unchanged.
- Reset mid-frame:
  - Stimulus: assert reset in cycle 5 of a frame.
  - out=0 and busy=0 immediately, and no done pulse occurs.
  - After release, a new 8'h81 frame transmits 1,0,1,1,0,0,0,0,0,0,1,0.
